// File: rtl/voting_seq_tally.sv
// Sequential voting tally.
// Ballots arrive one per cycle over a valid/ready handshake and are counted
// per candidate. A linear scan of the tallies then produces the winner, the
// winning count, a tie flag and a strict-majority flag.
module voting_seq_tally #(
  parameter int N = 2,  // log2 of candidate count
  parameter int M = 2   // log2 of maximum ballots per election
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         close,
  input  logic         vote_valid,
  input  logic [N-1:0] vote,
  output logic         vote_ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] winner,
  output logic [M:0]   winner_count,
  output logic [M:0]   total,
  output logic         tie,
  output logic         majority
);

  localparam int         NC   = 1 << N;
  localparam logic [M:0] MAXV = {1'b1, {M{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SCAN    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t       state, state_next;

  logic [M:0]   count [NC];
  logic [M:0]   total_q;
  logic [N-1:0] idx;
  logic [M:0]   best;
  logic [N-1:0] win_q;
  logic         tie_q;
  logic         maj_q;

  logic         accept;
  logic         last_scan;
  logic [M:0]   cand;
  logic [M:0]   best_next;
  logic [N-1:0] win_next;
  logic         tie_next;

  assign accept    = vote_valid && (state == COLLECT);
  assign last_scan = (state == SCAN) && (idx == N'(NC - 1));
  assign cand      = count[idx];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    state_next = state;
    vote_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = COLLECT;
      end
      COLLECT: begin
        vote_ready = 1'b1;
        busy       = 1'b1;
        if ((accept && (total_q == MAXV - (M+1)'(1))) || close) state_next = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last_scan) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = COLLECT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Scan step: fold candidate idx into the running best; ties keep the lower ID.
  always_comb begin
    best_next = best;
    win_next  = win_q;
    tie_next  = tie_q;
    if (idx == '0) begin
      best_next = cand;
      win_next  = '0;
      tie_next  = 1'b0;
    end else if (cand > best) begin
      best_next = cand;
      win_next  = idx;
      tie_next  = 1'b0;
    end else if (cand == best) begin
      tie_next  = 1'b1;
    end
  end

  // Tally counters, scan index and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the tally array is small and must read as zero after reset,
      // so it is reset explicitly like ordinary flops rather than left as RAM.
      for (int c = 0; c < NC; c++) count[c] <= '0;
      total_q <= '0;
      idx     <= '0;
      best    <= '0;
      win_q   <= '0;
      tie_q   <= 1'b0;
      maj_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int c = 0; c < NC; c++) count[c] <= '0;
            total_q <= '0;
            idx     <= '0;
            best    <= '0;
            win_q   <= '0;
            tie_q   <= 1'b0;
            maj_q   <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept) begin
            count[vote] <= count[vote] + (M+1)'(1);
            total_q     <= total_q + (M+1)'(1);
          end
          idx <= '0;
        end
        SCAN: begin
          best  <= best_next;
          win_q <= win_next;
          tie_q <= tie_next;
          idx   <= idx + N'(1);
          // Doubled best compared at M+2 bits so MAXV*2 cannot overflow.
          if (last_scan) maj_q <= {best_next, 1'b0} > {1'b0, total_q};
        end
        default: ;
      endcase
    end
  end

  assign winner       = win_q;
  assign winner_count = best;
  assign total        = total_q;
  assign tie          = tie_q;
  assign majority     = maj_q;

endmodule

// File: tb/tb_voting_seq_tally.sv
// Self-checking bench for voting_seq_tally: directed scenarios followed by
// random elections, all compared against a ballot-list reference model.
module tb_voting_seq_tally;

  localparam int N    = 2;
  localparam int M    = 2;
  localparam int NC   = 1 << N;
  localparam int MAXV = 1 << M;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         close;
  logic         vote_valid;
  logic [N-1:0] vote;
  logic         vote_ready;
  logic         busy;
  logic         done;
  logic [N-1:0] winner;
  logic [M:0]   winner_count;
  logic [M:0]   total;
  logic         tie;
  logic         majority;

  voting_seq_tally #(.N(N), .M(M)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .close        (close),
    .vote_valid   (vote_valid),
    .vote         (vote),
    .vote_ready   (vote_ready),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .winner_count (winner_count),
    .total        (total),
    .tie          (tie),
    .majority     (majority)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int close_cyc = 0;

  // Reference model: the list of accepted ballots plus the election phase.
  int q[$];
  bit m_open = 0;
  bit m_scan = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_cycle(input bit st, input bit vv, input logic [N-1:0] v, input bit cls);
    bit started;
    bit closed;
    started = 0;
    closed  = 0;
    start = st; vote_valid = vv; vote = v; close = cls;
    check("vote_ready", 32'(vote_ready), 32'(m_open));
    check("busy", 32'(busy), 32'(m_open || m_scan));
    if (m_open) begin
      if (vv) q.push_back(int'(v));
      if (q.size() == MAXV || cls) begin
        m_open = 0;
        m_scan = 1;
        closed = 1;
      end
    end else if (st && !m_scan) begin
      q.delete();
      m_open  = 1;
      started = 1;
    end
    tick();
    start = 0; vote_valid = 0; close = 0;
    if (closed) close_cyc = cyc;
    if (started) begin
      check("start_total_clear", 32'(total), 0);
      check("start_done_low", 32'(done), 0);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 1);
    check("scan_latency", 32'(cyc - close_cyc), 32'(NC));
    m_scan = 0;
  endtask

  task automatic check_results(input string tag);
    int tally [NC];
    int best, win, tot;
    bit exp_tie, exp_maj;
    foreach (tally[c]) tally[c] = 0;
    foreach (q[k]) tally[q[k]]++;
    tot  = q.size();
    best = -1;
    win  = 0;
    for (int c = 0; c < NC; c++)
      if (tally[c] > best) begin best = tally[c]; win = c; end
    exp_tie = 0;
    for (int c = 0; c < NC; c++)
      if (c != win && tally[c] == best) exp_tie = 1;
    exp_maj = (2 * best) > tot;
    check({tag, "_winner"}, 32'(winner), 32'(win));
    check({tag, "_count"}, 32'(winner_count), 32'(best));
    check({tag, "_total"}, 32'(total), 32'(tot));
    check({tag, "_tie"}, 32'(tie), 32'(exp_tie));
    check({tag, "_majority"}, 32'(majority), 32'(exp_maj));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, 32'(vote_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_winner"}, 32'(winner), 0);
    check({tag, "_count"}, 32'(winner_count), 0);
    check({tag, "_total"}, 32'(total), 0);
    check({tag, "_tie"}, 32'(tie), 0);
    check({tag, "_majority"}, 32'(majority), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; close = 0; vote_valid = 0; vote = '0;

    // Reset held three cycles, then released.
    repeat (3) tick();
    check_cleared("reset");
    rst_n = 1'b1;
    tick();
    check_cleared("idle");

    // Votes 2,2,1,2 back to back: auto-close at MAXV.
    drive_cycle(1, 0, 0, 0);
    check("ready_after_start", 32'(vote_ready), 1);
    drive_cycle(0, 1, 2, 0);
    drive_cycle(0, 1, 2, 0);
    drive_cycle(0, 1, 1, 0);
    drive_cycle(0, 1, 2, 0);
    check("ready_drop_at_maxv", 32'(vote_ready), 0);
    wait_done();
    check_results("t2");
    check("t2_winner_lit", 32'(winner), 2);
    check("t2_count_lit", 32'(winner_count), 3);

    // Votes 1,3,3,1: tie resolves to lowest ID.
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 1, 1, 0);
    drive_cycle(0, 1, 3, 0);
    drive_cycle(0, 1, 3, 0);
    drive_cycle(0, 1, 1, 0);
    wait_done();
    check_results("t3");
    check("t3_tie_lit", 32'(tie), 1);

    // Votes with gaps; close coincides with a third vote; late vote ignored.
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 0, 3, 0);
    drive_cycle(0, 1, 3, 0);
    drive_cycle(0, 0, 1, 0);
    drive_cycle(0, 1, 3, 1);
    drive_cycle(0, 1, 2, 0);
    wait_done();
    check_results("t4");
    check("t4_total_lit", 32'(total), 3);

    // Zero ballots.
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 1);
    wait_done();
    check_results("t5");
    check("t5_tie_lit", 32'(tie), 1);

    // Reset during SCAN aborts the election.
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 1, 1, 0);
    drive_cycle(0, 1, 2, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete(); m_open = 0; m_scan = 0;
    check_cleared("midscan_reset");

    // New election; start pulses while busy must be ignored.
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 1, 0, 0);
    drive_cycle(0, 1, 0, 0);
    drive_cycle(1, 1, 0, 0);
    drive_cycle(0, 1, 0, 0);
    drive_cycle(1, 0, 0, 0);
    wait_done();
    check_results("t6");
    check("t6_count_lit", 32'(winner_count), 4);

    // Random elections.
    for (int e = 0; e < 30; e++) begin
      drive_cycle(1, 0, 0, 0);
      for (int k = 0; k < 10 && m_open; k++)
        drive_cycle(($urandom % 6) == 0, ($urandom % 4) != 0,
                    N'($urandom), ($urandom % 8) == 0);
      if (m_open) drive_cycle(0, 0, 0, 1);
      wait_done();
      check_results("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/voting_seq_tally.md
Name: voting_seq_tally

Overview:
- Sequential successor to the combinational voting core.
- Accepts ballots one per cycle over a valid/ready handshake and tallies them per candidate.
- Scans the tallies to produce the winner, winning count, tie flag and strict-majority flag.
- Scales to large voter counts without instantiating 2^M ballot inputs; sits between the ballot input stream and the result output of the MPC voting circuits.

Parameters:
- N, 2: log2 of number of candidates (NC = 2^N candidates, IDs 0..NC-1).
- M, 2: log2 of maximum number of voters (MAXV = 2^M ballots per election).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; opens a new election (honoured only in IDLE or DONE).
- close  in  1  ends collection early (honoured only in COLLECT).
- vote_valid  in  1  ballot present on vote.
- vote  in  N  candidate ID of the ballot.
- vote_ready  out  1  high only in COLLECT.
- busy  out  1  high in COLLECT or SCAN.
- done  out  1  high in DONE; results stable while high.
- winner  out  N  winning candidate ID.
- winner_count  out  M+1  tally of the winner.
- total  out  M+1  ballots accepted this election.
- tie  out  1  another candidate has a count equal to winner_count.
- majority  out  1  2*winner_count > total.

Behaviour:
- Reset: when rst_n=0 at a clock edge, state=IDLE and every output and counter is 0. Reset overrides all other inputs and aborts any election in progress.
- FSM states: IDLE, COLLECT, SCAN, DONE.
- IDLE/DONE -> COLLECT on start.
  - On that edge, all NC counters, total, winner, winner_count, tie and majority clear to 0, and done drops.
  - start in COLLECT or SCAN is ignored.
- COLLECT: vote_ready=1. Acceptance is vote_valid && vote_ready.
  - Each acceptance increments count[vote] and total by 1.
  - COLLECT -> SCAN on the edge where total becomes MAXV, or on close=1.
  - If close and a valid vote arrive in the same cycle, the vote is accepted, then the FSM goes to SCAN.
  - At total==MAXV, vote_ready drops the next cycle; no ballot beyond MAXV is ever counted.
- Counters are M+1 bits, so MAXV is representable without wrap and no saturation logic is required.
- SCAN: one candidate per cycle, index i = 0..NC-1, for NC cycles.
  - Best is initialised from candidate 0.
  - For i>0: if count[i] > best, then best=count[i], winner=i, tie=0. Else if count[i] == best, tie=1.
  - Ties resolve to the lowest candidate ID.
  - On the final scan cycle, go to DONE and register majority from (best<<1) > total, computed at M+2 bits.
- Latency: if the last acceptance (or close) is at edge T, SCAN occupies edges T+1..T+NC, and done=1 with all results valid from edge T+NC.
- DONE: outputs hold until start or reset.
- Zero ballots (start, then close with no votes): winner=0, winner_count=0, total=0, majority=0, and tie=1 when NC>1.
- N=0 (single candidate) is not supported.
- vote is ignored when vote_valid=0, and in every state other than COLLECT.

Test Plan:
- N=2, M=2, reset held 3 cycles then released -> all outputs 0, vote_ready=0, state IDLE; start -> vote_ready=1 next cycle.
- Votes 2,2,1,2 on consecutive cycles -> vote_ready drops after the 4th; done asserted 4 cycles later; winner=2, winner_count=3, total=4, tie=0, majority=1.
- Votes 1,3,3,1 -> winner=1, winner_count=2, tie=1, majority=0 (lowest-ID tie-break).
- Votes 0,3 with vote_valid gaps, then close together with a third vote 3 -> total=3, winner=3, winner_count=2, majority=1; a vote_valid pulse after close is not counted.
- start then close with no votes -> winner=0, winner_count=0, total=0, tie=1, majority=0.
- rst_n=0 during SCAN mid-election -> IDLE next edge with all outputs 0; a new start plus votes 0,0,0,0 -> winner=0, winner_count=4, majority=1; start asserted while busy has no effect.
